// File: rtl/ip_ttl_checksum_update.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ip_ttl_checksum_update: AXI-Stream IPv4 TTL decrement and checksum rewrite |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ip_ttl_checksum_update #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  input  logic [31:0]                       counter_reset,
  output logic [31:0]                       modified_count,
  output logic [31:0]                       ttl_expired_count,
  output logic [31:0]                       bad_csum_count
);

  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  localparam logic [7:0]  VER_IHL_BASIC = 8'h45;

  logic                              first_beat;
  logic                              a_valid;
  logic                              a_first;
  logic                              a_last;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    a_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  a_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   a_user;
  logic                              b_valid;
  logic                              b_last;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    b_data;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  b_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   b_user;

  logic                              hold_beat0;
  logic                              a_adv;
  logic                              s_ready;
  logic                              s_acc;
  logic [7:0]                        ttl_dec;
  logic [19:0]                       rx_sum;
  logic [19:0]                       tx_sum;
  logic                              qualify;
  logic                              csum_ok;
  logic                              ttl_ok;
  logic                              rewrite;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    out_data;

  function automatic logic [15:0] fold_sum(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  // Beat 0 of a multi-beat packet waits in A until beat 1 is on the input,
  // since the last header word lives in beat 1.
  always_comb begin
    hold_beat0 = a_valid & a_first & ~a_last & ~S_AXIS_TVALID;
    a_adv      = a_valid & (~b_valid | M_AXIS_TREADY) & ~hold_beat0;
    s_ready    = ~a_valid | a_adv;
    s_acc      = S_AXIS_TVALID & s_ready;
  end

  always_comb begin
    ttl_dec = a_data[79:72] - 8'd1;
    rx_sum  = {4'd0, S_AXIS_TDATA[255:240]};
    tx_sum  = {4'd0, S_AXIS_TDATA[255:240]};
    for (int i = 0; i < 9; i++) begin
      rx_sum = rx_sum + {4'd0, a_data[143-16*i -: 16]};
      if (i == 4) begin
        tx_sum = tx_sum + {4'd0, ttl_dec, a_data[71:64]};
      end else if (i != 5) begin
        tx_sum = tx_sum + {4'd0, a_data[143-16*i -: 16]};
      end
    end
    qualify  = a_first & ~a_last & (a_data[159:144] == ETH_IPV4) &
               (a_data[143:136] == VER_IHL_BASIC);
    csum_ok  = (fold_sum(rx_sum) == 16'hFFFF);
    ttl_ok   = (a_data[79:72] >= 8'd2);
    rewrite  = qualify & csum_ok & ttl_ok;
    out_data = a_data;
    if (rewrite) begin
      out_data[79:72] = ttl_dec;
      out_data[63:48] = ~fold_sum(tx_sum);
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      first_beat <= 1'b1;
      a_valid    <= 1'b0;
      a_first    <= 1'b0;
      a_last     <= 1'b0;
      a_data     <= '0;
      a_strb     <= '0;
      a_user     <= '0;
      b_valid    <= 1'b0;
      b_last     <= 1'b0;
      b_data     <= '0;
      b_strb     <= '0;
      b_user     <= '0;
    end else begin
      if (s_acc) begin
        a_valid    <= 1'b1;
        a_first    <= first_beat;
        a_last     <= S_AXIS_TLAST;
        a_data     <= S_AXIS_TDATA;
        a_strb     <= S_AXIS_TSTRB;
        a_user     <= S_AXIS_TUSER;
        first_beat <= S_AXIS_TLAST;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end

      if (a_adv) begin
        b_valid <= 1'b1;
        b_last  <= a_last;
        b_data  <= out_data;
        b_strb  <= a_strb;
        b_user  <= a_user;
      end else if (M_AXIS_TREADY) begin
        b_valid <= 1'b0;
      end
    end
  end

  // A clear request wins over an increment landing in the same cycle.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      modified_count    <= 32'd0;
      ttl_expired_count <= 32'd0;
      bad_csum_count    <= 32'd0;
    end else if (counter_reset == 32'd1) begin
      modified_count    <= 32'd0;
      ttl_expired_count <= 32'd0;
      bad_csum_count    <= 32'd0;
    end else if (a_adv && qualify) begin
      if (!csum_ok) begin
        bad_csum_count <= bad_csum_count + 32'd1;
      end else if (!ttl_ok) begin
        ttl_expired_count <= ttl_expired_count + 32'd1;
      end else begin
        modified_count <= modified_count + 32'd1;
      end
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = b_valid;
  assign M_AXIS_TLAST  = b_last;
  assign M_AXIS_TDATA  = b_data;
  assign M_AXIS_TSTRB  = b_strb;
  assign M_AXIS_TUSER  = b_user;

endmodule
`default_nettype wire

// File: tb/tb_ip_ttl_checksum_update.sv
`default_nettype none
// Bench for ip_ttl_checksum_update: directed header vectors plus randomized
// traffic scored against a byte-level IPv4 header model.
module tb_ip_ttl_checksum_update;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [31:0]  counter_reset;
  logic [31:0]  modified_count;
  logic [31:0]  ttl_expired_count;
  logic [31:0]  bad_csum_count;

  int checks   = 0;
  int failures = 0;

  logic [255:0] pd [0:7];
  logic [31:0]  ps [0:7];
  logic [127:0] pu [0:7];
  int           pn;

  logic [255:0] exp_data [$];
  logic [31:0]  exp_strb [$];
  logic [127:0] exp_user [$];
  logic         exp_last [$];
  logic [31:0]  exp_mod, exp_ttl, exp_bad;

  logic         hold_pending = 1'b0;
  logic [255:0] prev_data;
  logic [31:0]  prev_strb;
  logic [127:0] prev_user;
  logic         prev_last;
  logic         rnd_done;

  always #5 clk = ~clk;

  ip_ttl_checksum_update dut (
    .AXI_ACLK          (clk),
    .AXI_RESETN        (rst_n),
    .S_AXIS_TDATA      (s_tdata),
    .S_AXIS_TSTRB      (s_tstrb),
    .S_AXIS_TUSER      (s_tuser),
    .S_AXIS_TVALID     (s_tvalid),
    .S_AXIS_TREADY     (s_tready),
    .S_AXIS_TLAST      (s_tlast),
    .M_AXIS_TDATA      (m_tdata),
    .M_AXIS_TSTRB      (m_tstrb),
    .M_AXIS_TUSER      (m_tuser),
    .M_AXIS_TVALID     (m_tvalid),
    .M_AXIS_TREADY     (m_tready),
    .M_AXIS_TLAST      (m_tlast),
    .counter_reset     (counter_reset),
    .modified_count    (modified_count),
    .ttl_expired_count (ttl_expired_count),
    .bad_csum_count    (bad_csum_count)
  );

  // Ones-complement sum of the 20-byte IPv4 header; header byte k is beat-0
  // byte 14+k for k<18, and the last two bytes come from beat 1.
  function automatic logic [15:0] hdr_sum(input logic [255:0] b0, input logic [15:0] dst_lo);
    logic [7:0] h [0:19];
    int acc;
    acc = 0;
    for (int k = 0; k < 18; k++) h[k] = b0[255-8*(14+k) -: 8];
    h[18] = dst_lo[15:8];
    h[19] = dst_lo[7:0];
    for (int j = 0; j < 10; j++) begin
      acc = acc + int'({h[2*j], h[2*j+1]});
      if (acc > 65535) acc = acc - 65535;
    end
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tstrb !== prev_strb ||
            m_tuser !== prev_user || m_tlast !== prev_last) begin
          failures++;
          $display("FAIL hold_stable: got valid=%b data=%h want valid=1 data=%h", m_tvalid, m_tdata, prev_data);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL out_beat: got unexpected beat data=%h want no beat", m_tdata);
        end else begin
          if (m_tdata !== exp_data[0] || m_tstrb !== exp_strb[0] ||
              m_tuser !== exp_user[0] || m_tlast !== exp_last[0]) begin
            failures++;
            $display("FAIL out_beat: got data=%h strb=%h last=%b want data=%h strb=%h last=%b",
                     m_tdata, m_tstrb, m_tlast, exp_data[0], exp_strb[0], exp_last[0]);
          end
          void'(exp_data.pop_front());
          void'(exp_strb.pop_front());
          void'(exp_user.pop_front());
          void'(exp_last.pop_front());
        end
      end
      hold_pending = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_strb = m_tstrb;
      prev_user = m_tuser;
      prev_last = m_tlast;
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic rand_beats(input int n);
    pn = n;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) pd[i][32*w +: 32] = $urandom;
      ps[i] = $urandom;
      for (int w = 0; w < 4; w++) pu[i][32*w +: 32] = $urandom;
    end
  endtask

  task automatic build_pkt(input int n, input logic [15:0] eth, input logic [7:0] vihl,
                           input logic [7:0] ttl, input bit bad);
    logic [15:0] s;
    rand_beats(n);
    pd[0][159:144] = eth;
    pd[0][143:136] = vihl;
    pd[0][79:72]   = ttl;
    pd[0][63:48]   = 16'h0000;
    s = hdr_sum(pd[0], (n >= 2) ? pd[1][255:240] : 16'h0000);
    pd[0][63:48] = ~s ^ (bad ? 16'h0001 : 16'h0000);
  endtask

  task automatic build_fixed(input int n, input logic [15:0] eth, input logic [7:0] ttl,
                             input logic [15:0] csum);
    rand_beats(n);
    pd[0][159:144] = eth;
    pd[0][143:0]   = 144'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8;
    pd[0][79:72]   = ttl;
    pd[0][63:48]   = csum;
    pd[1][255:240] = 16'h00C7;
  endtask

  task automatic push_pkt(input logic [255:0] b0);
    for (int i = 0; i < pn; i++) begin
      exp_data.push_back(i == 0 ? b0 : pd[i]);
      exp_strb.push_back(ps[i]);
      exp_user.push_back(pu[i]);
      exp_last.push_back(i == pn - 1);
    end
  endtask

  task automatic model_pkt();
    logic [255:0] b0;
    logic [15:0]  s;
    b0 = pd[0];
    if (pn >= 2 && b0[159:144] == 16'h0800 && b0[143:136] == 8'h45) begin
      s = hdr_sum(b0, pd[1][255:240]);
      if (s != 16'hFFFF) begin
        exp_bad++;
      end else if (b0[79:72] <= 8'd1) begin
        exp_ttl++;
      end else begin
        b0[79:72] = b0[79:72] - 8'd1;
        b0[63:48] = 16'h0000;
        b0[63:48] = ~hdr_sum(b0, pd[1][255:240]);
        exp_mod++;
      end
    end
    push_pkt(b0);
  endtask

  task automatic drive_beat(input int i);
    int t;
    t = 0;
    s_tvalid = 1'b1;
    s_tdata  = pd[i];
    s_tstrb  = ps[i];
    s_tuser  = pu[i];
    s_tlast  = (i == pn - 1);
    @(negedge clk);
    while (!s_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout: got ready=0 for %0d cycles want ready=1", t);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drive_pkt(input int gap_max);
    for (int i = 0; i < pn; i++) begin
      drive_beat(i);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_data.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_data.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d beats outstanding want 0", exp_data.size());
      exp_data.delete(); exp_strb.delete(); exp_user.delete(); exp_last.delete();
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_counters(input string tag);
    checks += 3;
    if (modified_count !== exp_mod) begin
      failures++;
      $display("FAIL %s modified_count: got %0d want %0d", tag, modified_count, exp_mod);
    end
    if (ttl_expired_count !== exp_ttl) begin
      failures++;
      $display("FAIL %s ttl_expired_count: got %0d want %0d", tag, ttl_expired_count, exp_ttl);
    end
    if (bad_csum_count !== exp_bad) begin
      failures++;
      $display("FAIL %s bad_csum_count: got %0d want %0d", tag, bad_csum_count, exp_bad);
    end
  endtask

  task automatic test_reset();
    checks += 2;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tstrb !== '0 || m_tuser !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b last=%b data=%h want all 0", m_tvalid, m_tlast, m_tdata);
    end
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", s_tready);
    end
    test_counters("reset");
  endtask

  task automatic test_modify();
    logic [255:0] b0;
    build_fixed(3, 16'h0800, 8'h40, 16'hB861);
    b0 = pd[0];
    b0[79:64] = 16'h3F11;
    b0[63:48] = 16'hB961;
    push_pkt(b0);
    exp_mod++;
    drive_pkt(0);
    drain();
    test_counters("modify");
  endtask

  task automatic test_ttl_expired();
    build_fixed(3, 16'h0800, 8'h01, 16'hF761);
    push_pkt(pd[0]);
    exp_ttl++;
    drive_pkt(0);
    drain();
    test_counters("ttl_expired");
  endtask

  task automatic test_bad_csum();
    build_fixed(3, 16'h0800, 8'h40, 16'hB862);
    push_pkt(pd[0]);
    exp_bad++;
    drive_pkt(0);
    drain();
    test_counters("bad_csum");
  endtask

  task automatic test_arp();
    build_fixed(2, 16'h0806, 8'h40, 16'hB861);
    push_pkt(pd[0]);
    drive_pkt(0);
    drain();
    test_counters("arp");
  endtask

  task automatic test_single_beat();
    build_pkt(1, 16'h0800, 8'h45, 8'h40, 1'b0);
    model_pkt();
    drive_beat(0);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_latency1: got valid=%b want 0", m_tvalid);
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency2: got valid=%b want 1", m_tvalid);
    end
    drain();
    test_counters("single_beat");
  endtask

  task automatic test_gap();
    build_pkt(2, 16'h0800, 8'h45, 8'($urandom_range(2, 255)), 1'b0);
    model_pkt();
    drive_beat(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL gap_valid: got %b want 0 at gap cycle %0d", m_tvalid, c);
      end
    end
    @(posedge clk);
    #1;
    drive_beat(1);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL gap_beat0_emit: got valid=%b want 1", m_tvalid);
    end
    drain();
    test_counters("gap");
  endtask

  task automatic test_back_to_back();
    int kind, n;
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int p = 0; p < 100; p++) begin
          kind = $urandom_range(0, 5);
          n = (kind == 5) ? 1 : $urandom_range(2, 4);
          case (kind)
            0: build_pkt(n, 16'h0800, 8'h45, 8'($urandom_range(2, 255)), 1'b0);
            1: build_pkt(n, 16'h0800, 8'h45, 8'($urandom_range(0, 1)), 1'b0);
            2: build_pkt(n, 16'h0800, 8'h45, 8'($urandom_range(0, 255)), 1'b1);
            3: build_pkt(n, 16'h0806, 8'h45, 8'($urandom_range(2, 255)), 1'b0);
            4: build_pkt(n, 16'h0800, 8'h46, 8'($urandom_range(2, 255)), 1'b0);
            default: build_pkt(n, 16'h0800, 8'h45, 8'($urandom_range(2, 255)), 1'b0);
          endcase
          model_pkt();
          drive_pkt(2);
        end
        drain();
        rnd_done = 1'b1;
      end
    join
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    test_counters("back_to_back");
  endtask

  task automatic test_counter_reset();
    build_pkt(3, 16'h0800, 8'h45, 8'h20, 1'b0);
    model_pkt();
    drive_beat(0);
    counter_reset = 32'd1;
    drive_beat(1);
    counter_reset = 32'd0;
    exp_mod = 0;
    exp_ttl = 0;
    exp_bad = 0;
    drive_beat(2);
    drain();
    test_counters("counter_reset");
  endtask

  task automatic test_reset_mid_packet();
    m_tready = 1'b0;
    build_pkt(3, 16'h0800, 8'h45, 8'h30, 1'b0);
    drive_beat(0);
    drive_beat(1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tstrb !== '0 || m_tuser !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got valid=%b last=%b data=%h want all 0", m_tvalid, m_tlast, m_tdata);
    end
    exp_mod = 0;
    exp_ttl = 0;
    exp_bad = 0;
    test_counters("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    build_pkt(2, 16'h0800, 8'h45, 8'h30, 1'b0);
    model_pkt();
    drive_pkt(0);
    drain();
    test_counters("after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    s_tdata = '0;
    s_tstrb = '0;
    s_tuser = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    counter_reset = 32'd0;
    exp_mod = 0;
    exp_ttl = 0;
    exp_bad = 0;
    rnd_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_modify();
    test_ttl_expired();
    test_bad_csum();
    test_arp();
    test_single_beat();
    test_gap();
    test_back_to_back();
    test_counter_reset();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_ttl_checksum_update.md
Name: ip_ttl_checksum_update

Overview:
- AXI-Stream rewrite stage in the router output port lookup path. It sits downstream of the header-parse/partial-checksum delay stage.
- For each qualifying IPv4 packet it decrements TTL, recomputes the IPv4 header checksum and writes both back into beat 0.
- It holds beat 0 until beat 1 arrives, because the destination IP low half sits in beat 1.
- All other packets pass through unmodified. Modified, TTL-expired and bad-checksum packets are counted.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master stream data width (only 256 supported)
- C_S_AXIS_DATA_WIDTH, 256, slave stream data width (only 256 supported)
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width

Ports:
- AXI_ACLK  in  1  clock
- AXI_RESETN  in  1  reset, asynchronous, active-low
- S_AXIS_TDATA  in  256  input data
- S_AXIS_TSTRB  in  32  input byte strobes
- S_AXIS_TUSER  in  128  input sideband
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TREADY  out  1  input ready
- S_AXIS_TLAST  in  1  input last beat
- M_AXIS_TDATA  out  256  output data
- M_AXIS_TSTRB  out  32  output strobes
- M_AXIS_TUSER  out  128  output sideband
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  output ready
- M_AXIS_TLAST  out  1  output last beat
- counter_reset  in  32  value 1 synchronously clears all counters
- modified_count  out  32  packets rewritten
- ttl_expired_count  out  32  IPv4 packets with TTL <= 1
- bad_csum_count  out  32  IPv4 packets with an invalid incoming checksum

Behaviour:
- Byte n of a beat occupies TDATA[255-8n -: 8].
- Beat 0 field positions: ethertype [159:144]; ver/IHL [143:136]; TTL [79:72]; protocol [71:64]; checksum [63:48].
- Beat 1: dst IP low half at [255:240].
- Structure: stage A (hold) and stage B (output). Each stage has valid, data, strb, user and last registers. M_AXIS_* are driven directly from stage B.
- Beat-0 tracking: a flag first_beat is 1 after reset and after every accepted TLAST beat. A beat accepted while first_beat=1 is tagged beat 0.
- Wait condition: wait = A holds a tagged beat 0 with last=0, and S_AXIS_TVALID=0.
- A advances to B when A_valid & (!B_valid | M_AXIS_TREADY) & !wait.
- S_AXIS_TREADY = !A_valid | A_advance. S_AXIS_TREADY is never gated on input valid.
- B clears when (M_AXIS_TREADY & !A_advance).
- Steady-state throughput is 1 beat per cycle. Latency is 2 cycles from input accept to M_AXIS_TVALID for every beat except beat 0.
- Beat 0 emits in the cycle after beat 1 is accepted.
- Qualify rule, evaluated when beat 0 advances with beat 1 on the input: ethertype==16'h0800 & ver/IHL==8'h45 & last=0.
- Checksum check: sum the ten 16-bit header words (beat0 [143:128] through [15:0] in 16-bit steps, plus beat1 [255:240]) in 20 bits. Fold the carry twice. A result other than 16'hFFFF means bad checksum.
- Qualified, good checksum, TTL >= 2:
  - TTL is replaced by TTL-1.
  - A new checksum is computed over the nine words excluding [63:48], using the new TTL. Sum in 20 bits, fold twice, ones-complement, write into [63:48].
  - modified_count increments.
- Qualified, TTL <= 1: packet is unmodified and ttl_expired_count increments. Bad-checksum detection takes priority over TTL handling.
- Bad checksum: packet is unmodified and bad_csum_count increments.
- Non-qualified or single-beat packets: unmodified, no counter change.
- Strobes, TUSER and TLAST always pass unchanged.
- Counters: 32-bit, wrap from FFFFFFFF to 0. counter_reset==1 clears them, overriding any same-cycle increment.
- Reset (asynchronous, active-low): all valids 0, first_beat 1, counters 0, M_AXIS_TVALID 0, M_AXIS_TLAST 0, M_AXIS_TDATA/TSTRB/TUSER 0.
- Reset asserted mid-packet discards all partial beats. The next accepted beat is treated as beat 0.
- Backpressure: while M_AXIS_TREADY=0 and B is valid, B holds stable (AXI-Stream rule). A fills, then S_AXIS_TREADY drops. No beat is dropped or duplicated.

Test Plan:
- IPv4 header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 (ethertype 0800), 3 beats, M_AXIS_TREADY=1 -> output beat 0 [79:64]=16'h3F11, [63:48]=16'hB961; beats 1-2 bit-identical; modified_count=1.
- Same packet with TTL=01, checksum adjusted to valid -> output identical to input; ttl_expired_count=1; modified_count unchanged.
- Same packet with checksum B862 -> unmodified; bad_csum_count=1.
- Ethertype 0806 ARP, 2 beats -> unmodified, no counters change. A single-beat IPv4 packet (TLAST on beat 0) -> unmodified, emitted 2 cycles after accept.
- S_AXIS_TVALID gap of 5 cycles between beat 0 and beat 1 -> M_AXIS_TVALID stays 0 throughout the gap, then beat 0 appears modified. Random M_AXIS_TREADY toggling over 100 packets -> output matches reference model, no loss.
- counter_reset=1 pulsed while a modified packet's beat 0 advances -> modified_count=0. AXI_RESETN low mid-packet -> all outputs 0 immediately, and the next packet is processed correctly.
